// File: rtl/rnl_synapse_array.sv
// rnl_synapse_array: synaptic front end of the TNN neuron.
// Each synapse turns one temporally encoded input spike per gamma wave into a
// ramp-no-leak unary pulse that is exactly w cycles long. It also holds its
// weight and applies STDP inc/dec updates on the gamma pulse.

// One synapse: edge detect, RAMP FSM and weight register.
module rnl_synapse_lane #(
    parameter int WRES = 3
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            i_grst,
    input  logic            i_load_w,
    input  logic [WRES-1:0] i_w_init,
    input  logic            i_spike,
    input  logic            i_inc,
    input  logic            i_dec,
    output logic            o_resp,
    output logic [WRES-1:0] o_weight
);
    localparam logic [WRES-1:0] WMAX = '1;
    localparam logic [WRES-1:0] ONE  = {{(WRES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    state_t          r_state;
    logic [WRES-1:0] r_cnt;
    logic            r_resp;
    logic            r_prev;
    logic [WRES-1:0] r_w;
    logic            w_rise;

    assign w_rise   = i_spike & ~r_prev;
    assign o_resp   = r_resp;
    assign o_weight = r_w;

    // Spike history is updated every cycle. This means a pulse that spans grst is never re-detected.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_prev <= 1'b0;
        else       r_prev <= i_spike;
    end

    // RNL FSM. The counter latches the weight at spike arrival, so a later load_w leaves the ramp in progress alone.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_resp  <= 1'b0;
        end else if (i_grst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_resp  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        if (r_w != '0) begin
                            r_state <= RAMP;
                            r_cnt   <= r_w;
                            r_resp  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                RAMP: begin
                    if (r_cnt == ONE) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        r_resp  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - ONE;
                    end
                end
                DONE:    r_state <= DONE;
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_resp  <= 1'b0;
                end
            endcase
        end
    end

    // Weight register. load_w beats the STDP update, and STDP saturates at 0 and wmax.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_w <= '0;
        end else if (i_load_w) begin
            r_w <= i_w_init;
        end else if (i_grst) begin
            if (i_inc && !i_dec && r_w != WMAX)    r_w <= r_w + ONE;
            else if (i_dec && !i_inc && r_w != '0) r_w <= r_w - ONE;
        end
    end
endmodule

module rnl_synapse_array #(
    parameter int INP  = 4,
    parameter int WRES = 3
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                grst,
    input  logic                load_w,
    input  logic [INP*WRES-1:0] w_init,
    input  logic [INP-1:0]      input_spikes,
    input  logic [INP-1:0]      inc,
    input  logic [INP-1:0]      dec,
    output logic [INP-1:0]      resp_func,
    output logic [INP*WRES-1:0] weights
);
    for (genvar g = 0; g < INP; g++) begin : g_lane
        rnl_synapse_lane #(.WRES(WRES)) u_lane (
            .clk      (clk),
            .rstb     (rstb),
            .i_grst   (grst),
            .i_load_w (load_w),
            .i_w_init (w_init[g*WRES +: WRES]),
            .i_spike  (input_spikes[g]),
            .i_inc    (inc[g]),
            .i_dec    (dec[g]),
            .o_resp   (resp_func[g]),
            .o_weight (weights[g*WRES +: WRES])
        );
    end
endmodule

// File: tb/tb_rnl_synapse_array.sv
// Directed bench for rnl_synapse_array (INP=4, WRES=3).
module tb_rnl_synapse_array;
    logic        clk = 1'b0;
    logic        rstb;
    logic        grst;
    logic        load_w;
    logic [11:0] w_init;
    logic [3:0]  input_spikes;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic [3:0]  resp_func;
    logic [11:0] weights;

    int pass_cnt = 0;
    int total    = 0;
    int cnt [4];
    int sum;

    rnl_synapse_array #(.INP(4), .WRES(3)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .grst         (grst),
        .load_w       (load_w),
        .w_init       (w_init),
        .input_spikes (input_spikes),
        .inc          (inc),
        .dec          (dec),
        .resp_func    (resp_func),
        .weights      (weights)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pack per-synapse weights s0..s3 into the w_init/weights layout.
    function automatic logic [11:0] pk(input int s0, input int s1, input int s2, input int s3);
        return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    initial begin
        rstb = 1'b0; grst = 1'b0; load_w = 1'b0; w_init = '0;
        input_spikes = '0; inc = '0; dec = '0;
        tick(); tick();
        chk("reset_resp", 32'(resp_func), 32'h0);
        chk("reset_weights", 32'(weights), 32'h0);
        rstb = 1'b1;
        tick();

        // Load {7,3,0,1}.
        w_init = pk(7, 3, 0, 1); load_w = 1'b1; tick(); load_w = 1'b0;
        chk("load_weights", 32'(weights), 32'(pk(7, 3, 0, 1)));

        // RNL widths: an 8-cycle pulse on all synapses.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        input_spikes = 4'hF;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) chk("rnl_start", 32'(resp_func), 32'hB);
            for (int i = 0; i < 4; i++) cnt[i] += int'(resp_func[i]);
            if (c == 7) input_spikes = 4'h0;
        end
        chk("rnl_w0", 32'(cnt[0]), 32'd7);
        chk("rnl_w1", 32'(cnt[1]), 32'd3);
        chk("rnl_w2", 32'(cnt[2]), 32'd0);
        chk("rnl_w3", 32'(cnt[3]), 32'd1);

        // A second rise in the same wave is ignored.
        sum = 0;
        input_spikes = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int i = 0; i < 4; i++) sum += int'(resp_func[i]);
        end
        input_spikes = 4'h0; tick();
        chk("second_rise_ignored", 32'(sum), 32'd0);

        // grst with no inc/dec: weights hold and synapses re-arm.
        grst = 1'b1; tick(); grst = 1'b0;
        chk("grst_hold_weights", 32'(weights), 32'(pk(7, 3, 0, 1)));
        cnt[1] = 0;
        input_spikes = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            cnt[1] += int'(resp_func[1]);
        end
        input_spikes = 4'h0;
        chk("rearm_after_grst", 32'(cnt[1]), 32'd3);

        // Asynchronous reset in the middle of a ramp.
        input_spikes = 4'b0001; tick(); tick();
        chk("midramp_resp", 32'(resp_func), 32'h1);
        rstb = 1'b0; #1;
        chk("async_reset_resp", 32'(resp_func), 32'h0);
        chk("async_reset_weights", 32'(weights), 32'h0);
        rstb = 1'b1; input_spikes = 4'h0; tick();

        // STDP with saturation.
        w_init = pk(7, 0, 4, 4); load_w = 1'b1; tick(); load_w = 1'b0;
        chk("stdp_load", 32'(weights), 32'(pk(7, 0, 4, 4)));
        inc = 4'b1101; dec = 4'b1010;
        grst = 1'b1; tick(); grst = 1'b0;
        chk("stdp_update", 32'(weights), 32'(pk(7, 0, 5, 4)));
        tick(); tick(); tick();
        chk("stdp_no_grst", 32'(weights), 32'(pk(7, 0, 5, 4)));
        inc = 4'b0000; dec = 4'b0100;
        grst = 1'b1; tick(); grst = 1'b0; dec = 4'h0;
        chk("stdp_dec", 32'(weights), 32'(pk(7, 0, 4, 4)));

        // Truncation by grst, and a rise coincident with grst is dropped.
        w_init = pk(5, 3, 0, 0); load_w = 1'b1; tick(); load_w = 1'b0;
        input_spikes = 4'b0001; tick();
        chk("trunc_ramp_c0", 32'(resp_func), 32'h1);
        tick();
        chk("trunc_ramp_c1", 32'(resp_func), 32'h1);
        grst = 1'b1; input_spikes = 4'b0011; tick(); grst = 1'b0;
        chk("trunc_at_grst", 32'(resp_func), 32'h0);
        sum = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < 4; i++) sum += int'(resp_func[i]);
        end
        chk("coincident_rise_dropped", 32'(sum), 32'd0);
        input_spikes = 4'h0; tick();

        // load_w beats a coincident STDP increment.
        w_init = pk(2, 2, 2, 2); inc = 4'hF; load_w = 1'b1; grst = 1'b1;
        tick();
        load_w = 1'b0; grst = 1'b0; inc = 4'h0;
        chk("load_over_stdp", 32'(weights), 32'(pk(2, 2, 2, 2)));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
